// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Producer side of the IF/ID interface. It generates the fetch PC and issues
// in-order requests to instruction memory. A 2-entry tag queue pairs each
// response with its PC, and a 2-entry {pc, instr} FIFO absorbs responses while
// ID is stalled. The registered output bundle consumed by ID is
// pc_out / pc_plus2_out / instruction_out / valid_out.
// A redirect flushes buffered work. Responses that are still in flight are
// counted in 'drop' and discarded when they return.
// Optional feature: define IF_PERF_CNT_EN to add the saturating
// fetch_stall_cnt output (cycles spent stalled on a valid bundle).
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2_out,
    output logic [15:0] instruction_out,
    output logic        valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] fetch_stall_cnt
`endif
);

    localparam int DEPTH = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] fetch_pc_reg, fetch_pc_next;

    logic        tag_wr_ptr_reg, tag_wr_ptr_next;
    logic        tag_rd_ptr_reg, tag_rd_ptr_next;
    logic [1:0]  outstanding_reg, outstanding_next;
    logic [1:0]  drop_reg, drop_next;

    logic        fifo_wr_ptr_reg, fifo_wr_ptr_next;
    logic        fifo_rd_ptr_reg, fifo_rd_ptr_next;
    logic [1:0]  fifo_count_reg, fifo_count_next;

    logic [15:0] pc_out_next;
    logic [15:0] pc_plus2_out_next;
    logic [15:0] instruction_out_next;
    logic        valid_out_next;

    // Per-slot storage views, one slot per generate iteration
    logic [15:0] tag_slot [DEPTH];
    logic [15:0] fifo_pc_slot [DEPTH];
    logic [15:0] fifo_instr_slot [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [2:0]  occupancy;
    logic        issue;
    logic        resp_accept;
    logic        resp_drop;
    logic        resp_live;
    logic [15:0] resp_pc;
    logic        fifo_empty;
    logic        out_from_fifo;
    logic        out_bypass;
    logic        fifo_push;
    logic        fifo_pop;

    // Every request, buffered instruction and to-be-dropped response holds one
    // of the two slots. That keeps the FIFO from ever overflowing.
    assign occupancy = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg} + {1'b0, drop_reg};
    assign imem_req  = !redirect_valid && (occupancy < 3'd2);
    assign imem_addr = fetch_pc_reg;
    assign issue     = imem_req;

    // A response with nothing in flight is a protocol error and is ignored.
    assign resp_accept = imem_rvalid && ((drop_reg != 2'd0) || (outstanding_reg != 2'd0));
    assign resp_drop   = imem_rvalid && (drop_reg != 2'd0);
    assign resp_live   = imem_rvalid && (drop_reg == 2'd0) && (outstanding_reg != 2'd0);
    assign resp_pc     = tag_slot[tag_rd_ptr_reg];

    // The FIFO head always wins over a fresh response, so program order is kept.
    assign fifo_empty    = (fifo_count_reg == 2'd0);
    assign out_from_fifo = !redirect_valid && !stall && !fifo_empty;
    assign out_bypass    = !redirect_valid && !stall && fifo_empty && resp_live;
    assign fifo_pop      = out_from_fifo;
    assign fifo_push     = !redirect_valid && resp_live && !out_bypass;

    // ------------------------------------------------------------------
    // Slot storage (data only, no reset needed)
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [15:0] tag_q;
            logic [15:0] pc_q;
            logic [15:0] instr_q;

            // Capture the issued PC when the tag write pointer selects this slot
            always_ff @(posedge clk) begin
                if (issue && (tag_wr_ptr_reg == 1'(gi))) begin
                    tag_q <= fetch_pc_reg;
                end
            end

            // Capture a buffered {pc, instr} pair when the FIFO write pointer selects this slot
            always_ff @(posedge clk) begin
                if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    pc_q    <= resp_pc;
                    instr_q <= imem_rdata;
                end
            end

            assign tag_slot[gi]        = tag_q;
            assign fifo_pc_slot[gi]    = pc_q;
            assign fifo_instr_slot[gi] = instr_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state: fetch PC, tag queue, drop counter, FIFO bookkeeping
    // ------------------------------------------------------------------
    // Redirect clears all queued work. Each in-flight response then becomes a
    // drop, including responses already marked for dropping, minus the one
    // consumed this cycle.
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        tag_wr_ptr_next  = tag_wr_ptr_reg;
        tag_rd_ptr_next  = tag_rd_ptr_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        fifo_wr_ptr_next = fifo_wr_ptr_reg;
        fifo_rd_ptr_next = fifo_rd_ptr_reg;
        fifo_count_next  = fifo_count_reg;

        if (redirect_valid) begin
            fetch_pc_next    = {redirect_pc[15:1], 1'b0};
            tag_wr_ptr_next  = 1'b0;
            tag_rd_ptr_next  = 1'b0;
            outstanding_next = 2'd0;
            drop_next        = drop_reg + outstanding_reg - {1'b0, resp_accept};
            fifo_wr_ptr_next = 1'b0;
            fifo_rd_ptr_next = 1'b0;
            fifo_count_next  = 2'd0;
        end else begin
            if (issue) begin
                fetch_pc_next   = fetch_pc_reg + 16'd2;
                tag_wr_ptr_next = ~tag_wr_ptr_reg;
            end
            if (resp_live) begin
                tag_rd_ptr_next = ~tag_rd_ptr_reg;
            end
            outstanding_next = outstanding_reg + {1'b0, issue} - {1'b0, resp_live};
            drop_next        = drop_reg - {1'b0, resp_drop};

            if (fifo_push) begin
                fifo_wr_ptr_next = ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_next = ~fifo_rd_ptr_reg;
            end
            fifo_count_next = fifo_count_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // ------------------------------------------------------------------
    // Next-state: output bundle
    // ------------------------------------------------------------------
    // Redirect overrides stall. When no source is available, pc fields keep
    // their old value and only valid/instruction are cleared.
    always_comb begin
        pc_out_next          = pc_out;
        pc_plus2_out_next    = pc_plus2_out;
        instruction_out_next = instruction_out;
        valid_out_next       = valid_out;

        if (redirect_valid) begin
            valid_out_next       = 1'b0;
            instruction_out_next = 16'h0000;
        end else if (!stall) begin
            if (out_from_fifo) begin
                pc_out_next          = fifo_pc_slot[fifo_rd_ptr_reg];
                pc_plus2_out_next    = fifo_pc_slot[fifo_rd_ptr_reg] + 16'd2;
                instruction_out_next = fifo_instr_slot[fifo_rd_ptr_reg];
                valid_out_next       = 1'b1;
            end else if (out_bypass) begin
                pc_out_next          = resp_pc;
                pc_plus2_out_next    = resp_pc + 16'd2;
                instruction_out_next = imem_rdata;
                valid_out_next       = 1'b1;
            end else begin
                instruction_out_next = 16'h0000;
                valid_out_next       = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Fetch-side control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            tag_wr_ptr_reg  <= 1'b0;
            tag_rd_ptr_reg  <= 1'b0;
            outstanding_reg <= 2'd0;
            drop_reg        <= 2'd0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_count_reg  <= 2'd0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            tag_wr_ptr_reg  <= tag_wr_ptr_next;
            tag_rd_ptr_reg  <= tag_rd_ptr_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            fifo_wr_ptr_reg <= fifo_wr_ptr_next;
            fifo_rd_ptr_reg <= fifo_rd_ptr_next;
            fifo_count_reg  <= fifo_count_next;
        end
    end

    // Registered IF/ID bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out          <= 16'h0000;
            pc_plus2_out    <= 16'h0000;
            instruction_out <= 16'h0000;
            valid_out       <= 1'b0;
        end else begin
            pc_out          <= pc_out_next;
            pc_plus2_out    <= pc_plus2_out_next;
            instruction_out <= instruction_out_next;
            valid_out       <= valid_out_next;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Count cycles in which ID holds a real instruction under stall, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_stall_cnt <= 16'h0000;
        end else if (stall && valid_out && (fetch_stall_cnt != 16'hFFFF)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Randomised bench with an in-order memory of variable latency. The reference
// model tracks three things:
//   - the in-flight request list (each entry marked wrong-path after a redirect),
//   - the program-order list of correct-path PCs not yet presented,
//   - the number of correct-path instructions returned but not yet presented.
// The expected request, address and bundle for each cycle are derived from
// those three.
module tb_instruction_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2_out;
    logic [15:0] instruction_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_stall_cnt;
    logic [15:0] exp_cnt;
`endif

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .pc_plus2_out    (pc_plus2_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
        bit          wrong;
    } mreq_t;

    mreq_t       memq[$];
    logic [15:0] exp_stream[$];
    int          delivered;
    logic [15:0] exp_fetch;
    int          cyc;
    int          last_due;
    int          lat;
    bit          verbose;

    int n_compared;
    int n_mismatched;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h required %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0000;
        #1;
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_pc", {16'd0, pc_out}, 32'd0);
        check_eq("rst_pc2", {16'd0, pc_plus2_out}, 32'd0);
        check_eq("rst_instr", {16'd0, instruction_out}, 32'd0);
        check_eq("rst_addr", {16'd0, imem_addr}, {16'd0, RST_PC});
        memq.delete();
        exp_stream.delete();
        delivered = 0;
        exp_fetch = RST_PC;
        last_due  = 0;
`ifdef IF_PERF_CNT_EN
        exp_cnt = 16'h0000;
        check_eq("rst_cnt", {16'd0, fetch_stall_cnt}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle: drive the inputs, check the request, advance the
    // model, then check the bundle.
    task automatic step(input logic st, input logic rv, input logic [15:0] rpc);
        logic        resp;
        logic        exp_req;
        logic        present;
        logic [15:0] exp_pc;
        logic [15:0] prev_pc, prev_pc2, prev_instr;
        logic        prev_valid;
        mreq_t       head;
        int          c0;
        int          due;

        prev_pc    = pc_out;
        prev_pc2   = pc_plus2_out;
        prev_instr = instruction_out;
        prev_valid = valid_out;

        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        resp = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_word(memq[0].addr) : 16'($urandom);
        #1;
        exp_req = !rv && ((memq.size() + delivered) < 2);
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req && imem_req) begin
            check_eq("imem_addr", {16'd0, imem_addr}, {16'd0, exp_fetch});
        end

        c0 = cyc;
        @(posedge clk);
        cyc++;

        present = 1'b0;
        exp_pc  = 16'h0000;
        if (resp) begin
            head = memq.pop_front();
            if (!head.wrong && !rv) delivered++;
        end
        if (rv) begin
            foreach (memq[i]) memq[i].wrong = 1'b1;
            exp_stream.delete();
            delivered = 0;
            exp_fetch = {rpc[15:1], 1'b0};
        end else begin
            if (exp_req) begin
                due = c0 + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: exp_fetch, due: due, wrong: 1'b0});
                exp_stream.push_back(exp_fetch);
                exp_fetch = exp_fetch + 16'd2;
            end
            if (!st && delivered > 0) begin
                present = 1'b1;
                exp_pc  = exp_stream.pop_front();
                delivered--;
            end
        end
`ifdef IF_PERF_CNT_EN
        if (st && prev_valid && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif

        #1;
        if (rv) begin
            check_eq("redir_valid", {31'd0, valid_out}, 32'd0);
            check_eq("redir_instr", {16'd0, instruction_out}, 32'd0);
        end else if (st) begin
            check_eq("hold_valid", {31'd0, valid_out}, {31'd0, prev_valid});
            check_eq("hold_pc", {16'd0, pc_out}, {16'd0, prev_pc});
            check_eq("hold_pc2", {16'd0, pc_plus2_out}, {16'd0, prev_pc2});
            check_eq("hold_instr", {16'd0, instruction_out}, {16'd0, prev_instr});
        end else if (present) begin
            check_eq("out_valid", {31'd0, valid_out}, 32'd1);
            check_eq("out_pc", {16'd0, pc_out}, {16'd0, exp_pc});
            check_eq("out_pc2", {16'd0, pc_plus2_out}, {16'd0, exp_pc + 16'd2});
            check_eq("out_instr", {16'd0, instruction_out}, {16'd0, mem_word(exp_pc)});
            if (verbose) $display("bundle pc=%h pc2=%h instr=%h", pc_out, pc_plus2_out, instruction_out);
        end else begin
            check_eq("idle_valid", {31'd0, valid_out}, 32'd0);
            check_eq("idle_instr", {16'd0, instruction_out}, 32'd0);
            check_eq("idle_pc", {16'd0, pc_out}, {16'd0, prev_pc});
            check_eq("idle_pc2", {16'd0, pc_plus2_out}, {16'd0, prev_pc2});
        end
`ifdef IF_PERF_CNT_EN
        check_eq("stall_cnt", {16'd0, fetch_stall_cnt}, {16'd0, exp_cnt});
`endif
    endtask

    initial begin
        bit seen;
        n_compared   = 0;
        n_mismatched = 0;
        cyc      = 0;
        lat      = 1;
        verbose  = 1'b1;
        reset    = 1'b1;

        // Fetch from reset with 1-cycle memory
        do_reset();
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            if (i >= 1) check_eq("t1_valid", {31'd0, valid_out}, 32'd1);
        end

        // Stall for 3 cycles mid-stream, then resume
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000);
        check_eq("t2_req_off", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000);

        // Redirect with two requests outstanding; both late responses are dropped
        do_reset();
        lat = 3;
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0201);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            if (valid_out && !seen) begin
                check_eq("t3_first_pc", {16'd0, pc_out}, 32'h0200);
                seen = 1'b1;
            end
        end
        check_eq("t3_seen", {31'd0, seen}, 32'd1);

        // Redirect and stall together
        lat = 1;
        step(1'b1, 1'b1, 16'h0300);
        check_eq("t4_valid", {31'd0, valid_out}, 32'd0);
        check_eq("t4_instr", {16'd0, instruction_out}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 16'hFFFC);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            if (valid_out && pc_out == 16'hFFFE) begin
                check_eq("t5_pc2_wrap", {16'd0, pc_plus2_out}, 32'h0000);
                seen = 1'b1;
            end
        end
        check_eq("t5_seen", {31'd0, seen}, 32'd1);

`ifdef IF_PERF_CNT_EN
        // Five stalled cycles on a valid bundle
        do_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000);
        check_eq("t6_cnt", {16'd0, fetch_stall_cnt}, 32'd5);
`endif

        // Randomised traffic
        verbose = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                lat = $urandom_range(1, 3);
                step(($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 19) == 0),
                     16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
